// File: rtl/ibpl_cfg_cardlet.sv
// ibpl_cfg_cardlet: per-channel direction/polarity/debounce cardlet between DIOB pins and blackbox bus
module ibpl_cfg_cardlet #(
  parameter int N_CH = 6,
  parameter int IW = 8,
  parameter logic [N_CH-1:0] DIR_MASK = 6'h20,
  parameter logic [N_CH-1:0] INV_MASK = 6'h1F,
  parameter int DEB_CYCLES = 4,
  parameter int LED_STRETCH = 50000
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [N_CH-1:0] diob_in,
  output logic [N_CH-1:0] diob_out,
  output logic [N_CH-1:0] diob_dir,
  output logic [IW-1:0]   internal_in,
  input  logic [IW-1:0]   internal_out,
  input  logic [IW-1:0]   input_enable,
  input  logic [IW-1:0]   output_enable,
  input  logic [IW-1:0]   input_act,
  input  logic [IW-1:0]   output_act,
  input  logic            err_clr,
  output logic [IW-1:0]   diob_led1,
  output logic [IW-1:0]   diob_led2,
  output logic            plugin_error
);
  localparam int CW = DEB_CYCLES > 0 ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int LW = $clog2(LED_STRETCH + 1);
  logic [N_CH-1:0] s1, s2, in_val, act, led_on, oe, ie, io;
  logic cfg_err, unused_bits;
  assign oe = output_enable[N_CH-1:0];
  assign ie = input_enable[N_CH-1:0];
  assign io = internal_out[N_CH-1:0];
  assign unused_bits = ^{internal_out, input_enable, output_enable, input_act, output_act};
  assign diob_dir = DIR_MASK;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= diob_in ^ INV_MASK;
      s2 <= s1;
    end
  if (DEB_CYCLES == 0) begin : g_nodeb
    assign in_val = s2;
  end else begin : g_deb
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic f;
      logic [CW-1:0] cnt;
      // any return to the filtered level restarts the qualification window
      always_ff @(posedge clk or negedge nReset)
        if (!nReset) begin
          f <= 1'b0;
          cnt <= '0;
        end else if (s2[i] == f) cnt <= '0;
        else if (cnt == CW'(DEB_CYCLES - 1)) begin
          f <= s2[i];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      assign in_val[i] = f;
    end
  end
  assign internal_in = IW'(in_val & ~DIR_MASK);
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) diob_out <= '0;
    else diob_out <= DIR_MASK & ((oe & (io ^ INV_MASK)) | (~oe & INV_MASK));
  assign act = (DIR_MASK & output_act[N_CH-1:0]) | (~DIR_MASK & input_act[N_CH-1:0]);
  for (genvar i = 0; i < N_CH; i++) begin : g_led
    logic [LW-1:0] lc;
    always_ff @(posedge clk or negedge nReset)
      if (!nReset) lc <= '0;
      else if (act[i]) lc <= LW'(LED_STRETCH);
      else if (lc != '0) lc <= lc - 1'b1;
    assign led_on[i] = lc != '0;
  end
  assign diob_led1 = IW'(led_on);
  assign diob_led2 = IW'((DIR_MASK & oe) | (~DIR_MASK & ie));
  assign cfg_err = |((oe & ~ie & ~DIR_MASK) | (ie & ~oe & DIR_MASK));
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) plugin_error <= 1'b0;
    else plugin_error <= cfg_err | (plugin_error & ~err_clr);
endmodule

// File: tb/tb_ibpl_cfg_cardlet.sv
// tb_ibpl_cfg_cardlet: directed and randomized checks against a cycle-history reference model
module tb_ibpl_cfg_cardlet;
  localparam int N = 6, DEB = 4, L = 10;
  localparam logic [5:0] DIR = 6'h20, INV = 6'h1F;
  logic clk = 0, nReset = 0, err_clr = 0;
  logic [5:0] diob_in = 0;
  logic [7:0] internal_out = 0, input_enable = 0, output_enable = 0, input_act = 0, output_act = 0;
  logic [5:0] diob_out, diob_dir;
  logic [7:0] internal_in, diob_led1, diob_led2;
  logic plugin_error;
  int chk = 0, pass = 0;
  logic [5:0] p1, p2, mf, m_dout;
  logic [5:0] sh[$];
  longint cyc, last_act[N];
  bit has_act[N];
  bit m_err;

  ibpl_cfg_cardlet #(.N_CH(6), .IW(8), .DIR_MASK(DIR), .INV_MASK(INV), .DEB_CYCLES(DEB),
                     .LED_STRETCH(L)) dut (
    .clk(clk), .nReset(nReset), .diob_in(diob_in), .diob_out(diob_out), .diob_dir(diob_dir),
    .internal_in(internal_in), .internal_out(internal_out), .input_enable(input_enable),
    .output_enable(output_enable), .input_act(input_act), .output_act(output_act),
    .err_clr(err_clr), .diob_led1(diob_led1), .diob_led2(diob_led2), .plugin_error(plugin_error));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    p1 = 0; p2 = 0; mf = 0; m_dout = 0; m_err = 0; cyc = 0;
    sh.delete();
    for (int i = 0; i < N; i++) begin has_act[i] = 0; last_act[i] = 0; end
  endtask

  // filtered level flips once the last DEB synchronised samples all disagree with it
  task automatic model_update();
    bit all_d, cfg, a;
    sh.push_back(p2);
    if (sh.size() > 8) void'(sh.pop_front());
    for (int i = 0; i < N; i++)
      if (!DIR[i] && sh.size() >= DEB) begin
        all_d = 1;
        for (int j = 0; j < DEB; j++) if (sh[sh.size()-1-j][i] == mf[i]) all_d = 0;
        if (all_d) mf[i] = ~mf[i];
      end
    p2 = p1;
    p1 = diob_in ^ INV;
    cyc++;
    cfg = 0;
    for (int i = 0; i < N; i++) begin
      m_dout[i] = DIR[i] ? (output_enable[i] ? internal_out[i] ^ INV[i] : INV[i]) : 1'b0;
      a = DIR[i] ? output_act[i] : input_act[i];
      if (a) begin has_act[i] = 1; last_act[i] = cyc; end
      if ((!DIR[i] && output_enable[i] && !input_enable[i]) ||
          (DIR[i] && input_enable[i] && !output_enable[i])) cfg = 1;
    end
    m_err = cfg | (m_err & !err_clr);
  endtask

  function automatic logic [7:0] e_led1();
    logic [7:0] r = 0;
    for (int i = 0; i < N; i++) r[i] = has_act[i] && (cyc - last_act[i] < L);
    return r;
  endfunction

  function automatic logic [7:0] e_led2();
    logic [7:0] r = 0;
    for (int i = 0; i < N; i++) r[i] = DIR[i] ? output_enable[i] : input_enable[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    if (nReset) model_update();
    #1;
  endtask

  task automatic assert_rst();
    nReset = 0;
    model_reset();
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    nReset = 1;
  endtask

  task automatic test_reset();
    assert_rst();
    repeat (2) step();
    chk++; if (internal_in !== 8'h00) $display("FAIL reset_internal_in got %h want 00", internal_in); else pass++;
    chk++; if (diob_out !== 6'h00) $display("FAIL reset_diob_out got %h want 00", diob_out); else pass++;
    chk++; if (diob_led1 !== 8'h00) $display("FAIL reset_led1 got %h want 00", diob_led1); else pass++;
    chk++; if (plugin_error !== 1'b0) $display("FAIL reset_error got %b want 0", plugin_error); else pass++;
    chk++; if (diob_dir !== 6'h20) $display("FAIL reset_dir got %h want 20", diob_dir); else pass++;
    release_rst();
  endtask

  task automatic test_latency();
    int n = 0;
    repeat (10) step();
    chk++; if (internal_in !== 8'h1F) $display("FAIL idle_internal_in got %h want 1f", internal_in); else pass++;
    diob_in[0] = 1;
    do begin step(); n++; end while (internal_in[0] !== 1'b0 && n < 20);
    chk++; if (n != 6) $display("FAIL latency_ch0 got %0d cycles want 6", n); else pass++;
  endtask

  task automatic test_glitch();
    int low = 0;
    bit ok = 1;
    diob_in[1] = 1;
    repeat (3) begin step(); if (internal_in[1] !== 1'b1) ok = 0; end
    diob_in[1] = 0;
    repeat (12) begin step(); if (internal_in[1] !== 1'b1) ok = 0; end
    chk++; if (!ok) $display("FAIL glitch3_dropped got toggle want steady 1"); else pass++;
    diob_in[1] = 1;
    repeat (4) step();
    diob_in[1] = 0;
    repeat (16) begin step(); if (internal_in[1] === 1'b0) low++; end
    chk++; if (low != 4) $display("FAIL glitch4_pulse got %0d low cycles want 4", low); else pass++;
    chk++; if (internal_in[1] !== 1'b1) $display("FAIL glitch4_final got %b want 1", internal_in[1]); else pass++;
  endtask

  task automatic test_output();
    output_enable[5] = 1;
    internal_out[5] = 0;
    step();
    chk++; if (diob_out[5] !== 1'b0) $display("FAIL out5_low got %b want 0", diob_out[5]); else pass++;
    chk++; if (diob_led2 !== 8'h20) $display("FAIL led2_oe5 got %h want 20", diob_led2); else pass++;
    internal_out[5] = 1;
    internal_out[0] = 1;
    output_enable[0] = 1;
    input_enable[0] = 1;
    #1;
    chk++; if (diob_out[5] !== 1'b0) $display("FAIL out5_before_edge got %b want 0", diob_out[5]); else pass++;
    step();
    chk++; if (diob_out !== 6'h20) $display("FAIL out5_high got %h want 20", diob_out); else pass++;
    output_enable[5] = 0;
    step();
    chk++; if (diob_out[5] !== 1'b0) $display("FAIL out5_disabled got %b want 0", diob_out[5]); else pass++;
    internal_out = 0; output_enable = 0; input_enable = 0;
    step();
  endtask

  task automatic test_led();
    int n = 0;
    output_act[5] = 1;
    step();
    output_act[5] = 0;
    while (diob_led1[5] === 1'b1 && n < 100) begin n++; step(); end
    chk++; if (n != 10) $display("FAIL led_stretch got %0d cycles want 10", n); else pass++;
    n = 0;
    output_act[5] = 1;
    step();
    output_act[5] = 0;
    while (diob_led1[5] === 1'b1 && n < 100) begin
      n++;
      if (n == 5) output_act[5] = 1;
      step();
      output_act[5] = 0;
    end
    chk++; if (n != 15) $display("FAIL led_retrigger got %0d cycles want 15", n); else pass++;
  endtask

  task automatic test_error();
    output_enable[2] = 1;
    #1;
    chk++; if (plugin_error !== 1'b0) $display("FAIL err_before_edge got %b want 0", plugin_error); else pass++;
    step();
    chk++; if (plugin_error !== 1'b1) $display("FAIL err_set got %b want 1", plugin_error); else pass++;
    output_enable[2] = 0;
    step();
    chk++; if (plugin_error !== 1'b1) $display("FAIL err_sticky got %b want 1", plugin_error); else pass++;
    err_clr = 1;
    step();
    err_clr = 0;
    chk++; if (plugin_error !== 1'b0) $display("FAIL err_clear got %b want 0", plugin_error); else pass++;
    input_enable[5] = 1;
    err_clr = 1;
    step();
    chk++; if (plugin_error !== 1'b1) $display("FAIL err_clr_while_bad got %b want 1", plugin_error); else pass++;
    step();
    chk++; if (plugin_error !== 1'b1) $display("FAIL err_clr_hold got %b want 1", plugin_error); else pass++;
    input_enable[5] = 0;
    step();
    err_clr = 0;
    chk++; if (plugin_error !== 1'b0) $display("FAIL err_fixed_clear got %b want 0", plugin_error); else pass++;
  endtask

  task automatic test_reset_mid();
    bit ok = 1;
    diob_in = 6'h02;
    output_act[5] = 1;
    step();
    output_act[5] = 0;
    repeat (4) step();
    chk++; if (diob_led1[5] !== 1'b1) $display("FAIL mid_led_on got %b want 1", diob_led1[5]); else pass++;
    assert_rst();
    chk++; if (internal_in !== 8'h00) $display("FAIL mid_rst_internal got %h want 00", internal_in); else pass++;
    chk++; if (diob_led1 !== 8'h00) $display("FAIL mid_rst_led1 got %h want 00", diob_led1); else pass++;
    chk++; if (diob_out !== 6'h00) $display("FAIL mid_rst_out got %h want 00", diob_out); else pass++;
    step();
    release_rst();
    repeat (12) begin
      step();
      if (internal_in[1] !== 1'b0 || diob_led1 !== 8'h00) ok = 0;
      if (internal_in !== {2'b0, mf & ~DIR}) ok = 0;
    end
    chk++; if (!ok) $display("FAIL mid_no_glitch got %h led %h want %h led 00", internal_in, diob_led1, {2'b0, mf & ~DIR}); else pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) diob_in[i] = ~diob_in[i];
      internal_out = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        output_enable = 8'($urandom);
        input_enable = ($urandom_range(0, 1) != 0) ? 8'($urandom) : output_enable;
      end
      input_act = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
      output_act = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
      err_clr = $urandom_range(0, 3) == 0;
      #1;
      chk++; if (diob_led2 !== e_led2()) $display("FAIL rnd_led2 c%0d got %h want %h", c, diob_led2, e_led2()); else pass++;
      step();
      chk++; if (internal_in !== {2'b0, mf & ~DIR}) $display("FAIL rnd_internal_in c%0d got %h want %h", c, internal_in, {2'b0, mf & ~DIR}); else pass++;
      chk++; if (diob_out !== m_dout) $display("FAIL rnd_diob_out c%0d got %h want %h", c, diob_out, m_dout); else pass++;
      chk++; if (diob_led1 !== e_led1()) $display("FAIL rnd_led1 c%0d got %h want %h", c, diob_led1, e_led1()); else pass++;
      chk++; if (plugin_error !== m_err) $display("FAIL rnd_error c%0d got %b want %b", c, plugin_error, m_err); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_output();
    test_led();
    test_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
